// File: rtl/inserter_mb.sv
// Macroblock inserter: writes one MB_SIZE_L x MB_SIZE_W pixel block, streamed in
// raster order, into a linear frame memory at the latched top-left position.
//
// state | meaning
// IDLE  | waiting for start; bounds-checks mbnumber, pulses err on reject
// WRITE | accepting pixels, one registered memory write per accepted pixel
// DONE  | single cycle: final write presented, done asserted
module inserter_mb #(
    parameter int WIDTH     = 1280,
    parameter int LENGTH    = 720,
    parameter int MB_SIZE_L = 16,
    parameter int MB_SIZE_W = 16,
    parameter int ADDR_W    = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       mbnumber,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    output logic              pix_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [15:0] J_LAST = 16'(MB_SIZE_L - 1);
    localparam logic [15:0] K_LAST = 16'(MB_SIZE_W - 1);

    logic [1:0]  state;
    logic [15:0] row;
    logic [15:0] col;
    logic [15:0] j;
    logic [15:0] k;
    logic        in_bounds;
    logic        accept;
    logic [47:0] addr_full;

    // 17-bit sums so a position near 0xFFFF cannot wrap back into range
    assign in_bounds = (({1'b0, mbnumber[31:16]} + 17'(MB_SIZE_L)) <= 17'(LENGTH)) &&
                       (({1'b0, mbnumber[15:0]}  + 17'(MB_SIZE_W)) <= 17'(WIDTH));

    assign pix_ready = (state == WRITE);
    assign accept    = pix_ready && pix_valid;
    assign busy      = (state == WRITE) || (state == DONE);
    assign done      = (state == DONE);

    assign addr_full = ({32'd0, row} + {32'd0, j}) * 48'(WIDTH) + {32'd0, col} + {32'd0, k};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            j         <= '0;
            k         <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            mem_we <= accept;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (in_bounds) begin
                            row   <= mbnumber[31:16];
                            col   <= mbnumber[15:0];
                            j     <= '0;
                            k     <= '0;
                            state <= WRITE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (accept) begin
                        mem_wdata <= pix_data;
                        mem_addr  <= addr_full[ADDR_W-1:0];
                        if (k == K_LAST) begin
                            k <= '0;
                            j <= j + 16'd1;
                            if (j == J_LAST) begin
                                state <= DONE;
                            end
                        end else begin
                            k <= k + 16'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inserter_mb.sv
// Scoreboard bench for inserter_mb: expected writes are queued at start and
// matched against every mem_we cycle.
module tb_inserter_mb;

    localparam int WIDTH  = 1280;
    localparam int LENGTH = 720;
    localparam int MBL    = 16;
    localparam int MBW    = 16;
    localparam int AW     = 20;
    localparam int NPIX   = MBL * MBW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   mbnumber;
    logic          pix_valid;
    logic [7:0]    pix_data;
    logic          pix_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic          err;

    inserter_mb #(
        .WIDTH(WIDTH), .LENGTH(LENGTH), .MB_SIZE_L(MBL), .MB_SIZE_W(MBW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mbnumber(mbnumber),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t q[$];
    wr_t mon_e;
    int  n_we   = 0;
    int  n_done = 0;
    int  n_err  = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            n_we++;
            if (q.size() == 0) begin
                chk("unexp_we", {31'd0, mem_we}, 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("addr", {12'd0, mem_addr}, mon_e.addr);
                chk("data", {24'd0, mem_wdata}, mon_e.data);
            end
        end
        if (done) begin
            n_done++;
            chk("done_q_empty", q.size(), 0);
        end
        if (err) n_err++;
    end

    task automatic push_mb(input int row, input int col);
        wr_t e;
        for (int j = 0; j < MBL; j++) begin
            for (int k = 0; k < MBW; k++) begin
                e.addr = ((row + j) * WIDTH + col + k) % (1 << AW);
                e.data = (j * MBW + k) % 256;
                q.push_back(e);
            end
        end
    endtask

    // abort_at > 0 stops after that many accepted pixels, leaving the DUT mid-WRITE
    task automatic send_mb(input int row, input int col, input bit gaps,
                           input int abort_at, input bit poke);
        int n;
        int cyc;
        n = 0;
        cyc = 0;
        start = 1'b1;
        mbnumber = {row[15:0], col[15:0]};
        push_mb(row, col);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        while (n < NPIX && cyc < 4000) begin
            pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_data = n[7:0];
            if (poke && n >= 50 && n < 53) begin
                start = 1'b1;
                mbnumber = 32'h0000_0000;
            end else begin
                start = 1'b0;
            end
            if (pix_valid && pix_ready) n++;
            @(posedge clk);
            #1;
            cyc++;
            if (abort_at > 0 && n == abort_at) break;
        end
        pix_valid = 1'b0;
        start = 1'b0;
        chk("pix_accepted", n, (abort_at > 0) ? abort_at : NPIX);
        if (abort_at == 0) begin
            chk("done_state", {31'd0, done}, 32'd1);
            @(posedge clk);
            #1;
            chk("idle_after_done", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic oob(input int row, input int col);
        int e0;
        int w0;
        e0 = n_err;
        w0 = n_we;
        start = 1'b1;
        mbnumber = {row[15:0], col[15:0]};
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("oob_err_high", {31'd0, err}, 32'd1);
        chk("oob_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("oob_err_low", {31'd0, err}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("oob_err_count", n_err - e0, 1);
        chk("oob_no_we", n_we - w0, 0);
        chk("oob_busy_after", {31'd0, busy}, 32'd0);
    endtask

    int d0;
    int w0;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        mbnumber = 32'd0;
        pix_valid = 1'b0;
        pix_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {27'd0, pix_ready, mem_we, busy, done, err}, 32'd0);
        chk("rst_addr", {12'd0, mem_addr}, 32'd0);
        chk("rst_data", {24'd0, mem_wdata}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // top-left MB, no stalls
        d0 = n_done;
        send_mb(0, 0, 1'b0, 0, 1'b0);
        chk("mb00_done", n_done - d0, 1);

        // bottom-right MB; last address is the final pixel of the frame
        d0 = n_done;
        w0 = n_err;
        send_mb(704, 1264, 1'b0, 0, 1'b0);
        chk("br_done", n_done - d0, 1);
        chk("br_no_err", n_err - w0, 0);
        chk("br_last_addr", {12'd0, mem_addr}, 32'd921599);

        oob(705, 0);
        oob(0, 1265);

        // random valid gaps
        w0 = n_we;
        send_mb(0, 0, 1'b1, 0, 1'b0);
        chk("gap_we_count", n_we - w0, NPIX);

        // reset mid-WRITE after 100 pixels
        d0 = n_done;
        send_mb(0, 0, 1'b0, 100, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ctl", {27'd0, pix_ready, mem_we, busy, done, err}, 32'd0);
        chk("abort_addr", {12'd0, mem_addr}, 32'd0);
        chk("abort_data", {24'd0, mem_wdata}, 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        send_mb(0, 0, 1'b0, 0, 1'b0);
        chk("abort_done_count", n_done - d0, 1);

        // back-to-back MBs with a start poke mid-WRITE
        d0 = n_done;
        w0 = n_we;
        send_mb(0, 0, 1'b0, 0, 1'b1);
        send_mb(0, 16, 1'b0, 0, 1'b0);
        chk("b2b_done", n_done - d0, 2);
        chk("b2b_we_count", n_we - w0, 2 * NPIX);

        repeat (3) @(posedge clk);
        chk("q_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
